mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port instruction/data memory between the IF-stage fetch and the MEM-stage load/store.
//  Sequences each access through a fixed wait-state count and returns read data with a one-cycle done pulse.
//  Drives mem_busy into the stage FSM's mem_force input, so the MEM stage holds until its access retires.
// PARAMETERS
//  AW          16  memory address width
//  DW          16  memory data width
//  WAIT_CYCLES 2   cycles mem_cs is held per access (legal range 1..15)
//  DBG_STARVE  4   consecutive CPU grants, with dbg_req pending, before debug is forced (macro only)
// PORTS
//  clk        in   1   clock, rising edge
//  resetn     in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request; held high until if_done
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetched word; valid while if_done=1 and held until the next fetch completes
//  if_done    out  1   one-cycle fetch-complete pulse
//  d_req      in   1   data request; held high until d_done
//  d_we       in   1   1 = write, 0 = read
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_rdata    out  DW  read data; same validity rule as if_rdata
//  d_done     out  1   one-cycle data-complete pulse
//  mem_cs     out  1   memory chip select
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data; valid in the last ACCESS cycle
//  mem_busy   out  1   (state!=IDLE) | d_req, combinational
// BEHAVIOUR
//  Reset: state=IDLE, counter=0; every output 0, including the rdata registers and the starve counter.
//  Reset mid-access: the access is dropped and no done pulse is issued.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE:   if any request is pending, select the winner and latch owner, addr, we and wdata.
//           Load counter = WAIT_CYCLES-1, then go to ACCESS.
//   ACCESS: mem_cs=1; mem_we/addr/wdata come from the latches and are stable for the whole access.
//           Counter decrements each cycle. At 0, a read latches mem_rdata into the owner's rdata; go to DONE.
//   DONE:   mem_cs=0; the owner's done pulses for exactly one cycle; go to IDLE.
//  Priority: d_req beats if_req. Simultaneous requests: data is served first, fetch waits in IDLE.
//  Latency: a request sampled in IDLE at edge k gives done=1 during cycle k+WAIT_CYCLES+1.
//   Back-to-back throughput is therefore one access per WAIT_CYCLES+2 cycles.
//  Writes leave both rdata registers unchanged. Fetches are always reads (we forced 0).
//  A request dropped mid-access does not abort it: the access completes and done still pulses.
//  A request raised during ACCESS/DONE is not sampled until the next IDLE cycle.
//  Counter width is 4 bits. WAIT_CYCLES=1 gives a single ACCESS cycle with no wrap.
// CONFIGURATION
//  MEM_ARB_DBG_PORT_EN defined: adds a third requester for the debug loader.
//   Ports (same semantics as the data port): dbg_req, dbg_we, dbg_addr[AW], dbg_wdata[DW], dbg_rdata[DW], dbg_done.
//   Priority is d > if > dbg, except when starve_cnt==DBG_STARVE: then dbg wins.
//   starve_cnt counts CPU grants made while dbg_req=1. It clears on a dbg grant, or whenever dbg_req=0 in IDLE.
//   mem_busy also asserts while a dbg access is in flight.
//  Macro undefined: no dbg ports, no starve counter; two-way priority only.
// STRUCTURE
//  Shared package mem_arb_pkg:
//   - state encoding: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10
//   - owner encoding: OWN_IF=2'd0, OWN_D=2'd1, OWN_DBG=2'd2
//   - WAIT_CNT_W=4
//  Sub-module mem_arb_prio: combinational winner selection from requests plus starve flag.
//   It is the single place the priority rule lives. The FSM and latches stay in the top module.
// TESTING
//  1. Fetch only: if_req=1, if_addr=16'h0010, mem_rdata=16'hA5A5, WAIT_CYCLES=2
//     -> mem_cs high 2 cycles; if_done in cycle 3 after sampling; if_rdata=16'hA5A5.
//  2. Simultaneous: if_req=d_req=1, d_we=1, d_addr=16'h0200, d_wdata=16'h1234
//     -> write served first (mem_we=1, mem_addr=16'h0200), d_done; then fetch; if_rdata unaffected by the write.
//  3. Stall link: d_req raised in IDLE -> mem_busy=1 the same cycle; stays 1 until the IDLE cycle after d_done.
//  4. Reset mid-ACCESS: resetn=0 during cycle 1 of the access
//     -> all outputs 0 immediately; no done pulse follows; next request proceeds normally.
//  5. Request drop: if_req falls during ACCESS -> access still completes and if_done pulses once.
//  6. (MEM_ARB_DBG_PORT_EN) dbg_req held with alternating CPU requests
//     -> dbg_done occurs after exactly 4 CPU grants (DBG_STARVE=4).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OWN_IF  = 2'd0,
      OWN_D   = 2'd1,
      OWN_DBG = 2'd2
   } owner_t;

   localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - winner selection: data > fetch > debug, debug first when starved
module mem_arb_prio
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
   input  logic   dbg_req,
   input  logic   starve,
   output logic   grant,
   output owner_t winner
);
   always_comb begin
      grant  = if_req | d_req | dbg_req;
      winner = OWN_IF;
      if (starve && dbg_req)
         winner = OWN_DBG;
      else if (d_req)
         winner = OWN_D;
      else if (if_req)
         winner = OWN_IF;
      else if (dbg_req)
         winner = OWN_DBG;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory sharing between fetch and load/store
// MEM_ARB_DBG_PORT_EN adds a starvation-protected debug loader port.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW          = 16,
   parameter int DW          = 16,
   parameter int WAIT_CYCLES = 2
`ifdef MEM_ARB_DBG_PORT_EN
   ,
   parameter int DBG_STARVE  = 4
`endif
)(
   input  logic          clk,
   input  logic          resetn,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
`ifdef MEM_ARB_DBG_PORT_EN
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_done,
`endif
   output logic          mem_cs,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_busy
);
   state_t                state;
   owner_t                owner;
   owner_t                winner;
   logic                  grant;
   logic [WAIT_CNT_W-1:0] cnt;
   logic                  dbg_pending;
   logic                  starve;

`ifdef MEM_ARB_DBG_PORT_EN
   logic [WAIT_CNT_W-1:0] starve_cnt;
   assign dbg_pending = dbg_req;
   assign starve      = (starve_cnt == WAIT_CNT_W'(DBG_STARVE));
`else
   assign dbg_pending = 1'b0;
   assign starve      = 1'b0;
`endif

   mem_arb_prio u_prio (
      .if_req  (if_req),
      .d_req   (d_req),
      .dbg_req (dbg_pending),
      .starve  (starve),
      .grant   (grant),
      .winner  (winner)
   );

   // Any in-flight access (debug included) keeps the MEM stage held.
   assign mem_busy = (state != IDLE) | d_req;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         cnt       <= '0;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
         dbg_rdata  <= '0;
         dbg_done   <= 1'b0;
         starve_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  owner  <= winner;
                  cnt    <= WAIT_CNT_W'(WAIT_CYCLES - 1);
                  mem_cs <= 1'b1;
                  state  <= ACCESS;
                  case (winner)
                     OWN_D: begin
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_wdata <= d_wdata;
                     end
`ifdef MEM_ARB_DBG_PORT_EN
                     OWN_DBG: begin
                        mem_addr  <= dbg_addr;
                        mem_we    <= dbg_we;
                        mem_wdata <= dbg_wdata;
                     end
`endif
                     default: begin
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                     end
                  endcase
               end
`ifdef MEM_ARB_DBG_PORT_EN
               if (!dbg_req || (grant && winner == OWN_DBG))
                  starve_cnt <= '0;
               else if (grant)
                  starve_cnt <= starve_cnt + 1'b1;
`endif
            end
            ACCESS: begin
               if (cnt == '0) begin
                  mem_cs <= 1'b0;
                  state  <= DONE;
                  case (owner)
                     OWN_D: begin
                        d_done <= 1'b1;
                        if (!mem_we) d_rdata <= mem_rdata;
                     end
`ifdef MEM_ARB_DBG_PORT_EN
                     OWN_DBG: begin
                        dbg_done <= 1'b1;
                        if (!mem_we) dbg_rdata <= mem_rdata;
                     end
`endif
                     default: begin
                        if_done <= 1'b1;
                        if (!mem_we) if_rdata <= mem_rdata;
                     end
                  endcase
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if_done <= 1'b0;
               d_done  <= 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
               dbg_done <= 1'b0;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int W  = 2;

   logic          clk = 1'b0;
   logic          resetn;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          if_done, d_done;
   logic          mem_cs, mem_we, mem_busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_DBG_PORT_EN
   logic          dbg_req, dbg_we, dbg_done;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
`ifdef MEM_ARB_DBG_PORT_EN
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_rdata (dbg_rdata),
      .dbg_done  (dbg_done),
`endif
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_busy  (mem_busy)
   );

   // Memory device seen by the DUT, and the bench's own view of its contents.
   logic [DW-1:0] mem_arr [16];
   logic [DW-1:0] ref_mem [16];
   assign mem_rdata = mem_arr[mem_addr[3:0]];
   always @(posedge clk) if (mem_cs && mem_we) mem_arr[mem_addr[3:0]] <= mem_wdata;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_if_rdata = '0;
   logic [DW-1:0] exp_d_rdata  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          do_if;
      bit          do_d;
      bit          d_we;
      logic [15:0] if_addr;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      int          if_lat;
      int          d_lat;
   } vec_t;

   vec_t vecs[4];

   task automatic run_vec(input vec_t v);
      int cyc, if_seen, d_seen, cs_cnt, if_pulses, d_pulses;
      bit d_cur;
      cyc = 0; if_seen = 0; d_seen = 0; cs_cnt = 0; if_pulses = 0; d_pulses = 0;
      @(negedge clk);
      if_req = v.do_if; if_addr = v.if_addr;
      d_req = v.do_d; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
      #1;
      if (v.do_d) check("busy_on_dreq", mem_busy, 1);
      while ((if_req || d_req) && cyc < 40) begin
         @(posedge clk); #1; cyc++;
         if (mem_cs) begin
            cs_cnt++;
            d_cur = v.do_d && d_seen == 0;
            check("busy_in_access", mem_busy, 1);
            check("mem_addr", mem_addr, d_cur ? v.d_addr : v.if_addr);
            check("mem_we", mem_we, d_cur ? v.d_we : 1'b0);
            if (d_cur && v.d_we) check("mem_wdata", mem_wdata, v.d_wdata);
         end
         if (d_done) begin
            d_pulses++; d_seen = cyc;
            if (v.d_we) ref_mem[v.d_addr[3:0]] = v.d_wdata;
            else exp_d_rdata = ref_mem[v.d_addr[3:0]];
            check("d_rdata", d_rdata, exp_d_rdata);
            check("if_rdata_hold", if_rdata, exp_if_rdata);
         end
         if (if_done) begin
            if_pulses++; if_seen = cyc;
            exp_if_rdata = ref_mem[v.if_addr[3:0]];
            check("if_rdata", if_rdata, exp_if_rdata);
            check("d_rdata_hold", d_rdata, exp_d_rdata);
         end
         @(negedge clk);
         if (d_done) d_req = 1'b0;
         if (if_done) if_req = 1'b0;
      end
      if (cyc >= 40) check("access_timeout", 0, 1);
      @(posedge clk); #1;
      check("idle_if_done", if_done, 0);
      check("idle_d_done", d_done, 0);
      check("idle_busy", mem_busy, 0);
      check("cs_cycles", cs_cnt, W * (int'(v.do_if) + int'(v.do_d)));
      check("if_pulses", if_pulses, int'(v.do_if));
      check("d_pulses", d_pulses, int'(v.do_d));
      if (v.do_if) check("if_latency", if_seen, v.if_lat);
      if (v.do_d) check("d_latency", d_seen, v.d_lat);
   endtask

   initial begin
      int pulses, seen;
      vec_t rv;
      resetn = 1'b0; if_req = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
`ifdef MEM_ARB_DBG_PORT_EN
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
`endif
      for (int i = 0; i < 16; i++) begin
         mem_arr[i] = 16'($urandom);
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[0] = 16'hA5A5; ref_mem[0] = 16'hA5A5;
      #12;
      check("rst_if_done", if_done, 0);
      check("rst_d_done", d_done, 0);
      check("rst_mem_cs", mem_cs, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_busy", mem_busy, 0);
      @(negedge clk); resetn = 1'b1;

      vecs[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, W + 1, 0};
      vecs[1] = '{1, 1, 1, 16'h0010, 16'h0200, 16'h1234, 2 * W + 3, W + 1};
      vecs[2] = '{0, 1, 0, 16'h0000, 16'h0205, 16'h0000, 0, W + 1};
      vecs[3] = '{1, 1, 0, 16'h0033, 16'h0047, 16'h0000, 2 * W + 3, W + 1};
      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Reset during the first ACCESS cycle drops the fetch silently.
      @(negedge clk); if_req = 1; if_addr = 16'h0009;
      @(posedge clk); #1;
      check("rst_mid_cs_before", mem_cs, 1);
      resetn = 1'b0; #1;
      check("rst_mid_cs", mem_cs, 0);
      check("rst_mid_addr", mem_addr, 0);
      check("rst_mid_if_rdata", if_rdata, 0);
      check("rst_mid_d_rdata", d_rdata, 0);
      exp_if_rdata = '0; exp_d_rdata = '0;
      if_req = 0;
      @(negedge clk); resetn = 1'b1;
      pulses = 0;
      for (int c = 0; c < W + 4; c++) begin
         @(posedge clk); #1;
         if (if_done || d_done) pulses++;
      end
      check("rst_mid_no_done", pulses, 0);
      run_vec(vecs[0]);

      // Fetch request withdrawn during ACCESS still completes once.
      @(negedge clk); if_req = 1; if_addr = 16'h000B;
      @(posedge clk); #1;
      check("drop_cs", mem_cs, 1);
      @(negedge clk); if_req = 0;
      pulses = 0; seen = 0;
      for (int c = 2; c <= W + 4; c++) begin
         @(posedge clk); #1;
         if (if_done) begin
            pulses++; seen = c;
            exp_if_rdata = ref_mem[11];
            check("drop_if_rdata", if_rdata, exp_if_rdata);
         end
      end
      check("drop_pulses", pulses, 1);
      check("drop_latency", seen, W + 1);

      for (int n = 0; n < 30; n++) begin
         rv.do_d    = 1'($urandom_range(0, 1));
         rv.do_if   = 1'($urandom_range(0, 1));
         if (!rv.do_d) rv.do_if = 1'b1;
         rv.d_we    = 1'($urandom_range(0, 1));
         rv.if_addr = 16'($urandom);
         rv.d_addr  = 16'($urandom);
         rv.d_wdata = 16'($urandom);
         rv.d_lat   = W + 1;
         rv.if_lat  = rv.do_d ? (W + 2) + (W + 1) : W + 1;
         run_vec(rv);
      end

`ifdef MEM_ARB_DBG_PORT_EN
      begin
         int cpu;
         bit dseen, got, use_d;
         cpu = 0; dseen = 0; use_d = 0;
         @(negedge clk);
         dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0007;
         if_req = 1; if_addr = 16'h0003; d_we = 0; d_addr = 16'h0004;
         for (int c = 0; c < 200 && !dseen; c++) begin
            @(posedge clk); #1;
            if (dbg_done) begin
               dseen = 1;
               check("dbg_cpu_grants", cpu, 4);
               check("dbg_rdata", dbg_rdata, ref_mem[7]);
            end
            got = if_done | d_done;
            @(negedge clk);
            if (dseen) begin
               dbg_req = 0; if_req = 0; d_req = 0;
            end else if (got) begin
               cpu++; use_d = !use_d;
               if_req = !use_d; d_req = use_d;
            end
         end
         if (!dseen) check("dbg_timeout", 0, 1);
         repeat (3) @(posedge clk);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
